// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU issue scheduler.
//   op_t        : operation code presented at issue and reported at write-back
//   slot_t      : one write-back reservation entry {valid, op, dst, is_cond}
//   div_state_t : divider tracking state
//   CMP_LAT, MOV_LAT : fixed single-cycle latencies
//   max_of()    : helper used to size the reservation table
package fpu_sched_pkg;

   typedef enum logic [2:0] {
      ADD  = 3'd0,
      SUB  = 3'd1,
      MUL  = 3'd2,
      DIV  = 3'd3,
      CMP  = 3'd4,
      ITOF = 3'd5,
      MOV  = 3'd6
   } op_t;

   localparam int CMP_LAT = 1;
   localparam int MOV_LAT = 1;
   localparam int DST_W   = 5;
   localparam int N_UNITS = 6;

   typedef struct packed {
      logic             valid;
      op_t              op;
      logic [DST_W-1:0] dst;
      logic             is_cond;
   } slot_t;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_PEND = 2'd2
   } div_state_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fpu_sched_if.sv
// Issue and write-back bundle between the core and the FPU scheduler.
//   req_valid/req_ready : issue handshake, transfer when both high at CLK
//   req_op/req_dst/req_is_cond : operation, destination register, cond-file flag
//   wb_valid/wb_sel/wb_dst/wb_is_cond : shared write-back port
// master = core side, slave = scheduler side.
interface fpu_sched_if;
   import fpu_sched_pkg::*;

   logic             req_valid;
   logic             req_ready;
   op_t              req_op;
   logic [DST_W-1:0] req_dst;
   logic             req_is_cond;

   logic             wb_valid;
   op_t              wb_sel;
   logic [DST_W-1:0] wb_dst;
   logic             wb_is_cond;

   modport master (
      output req_valid, req_op, req_dst, req_is_cond,
      input  req_ready, wb_valid, wb_sel, wb_dst, wb_is_cond
   );

   modport slave (
      input  req_valid, req_op, req_dst, req_is_cond,
      output req_ready, wb_valid, wb_sel, wb_dst, wb_is_cond
   );

endinterface

// File: rtl/fpu_sched_rsv.sv
// Write-back reservation table. Slot k holds the result that reaches the
// write-back port k-1 cycles from now; slot 1 is the current write-back.
// Ports:
//   CLK, RST_N      : clock, synchronous active-low reset
//   rsv_en          : reserve the slot for the op being accepted this cycle
//   rsv_lat         : latency of the requested op (0 = not a fixed-latency op)
//   rsv_slot        : entry written on reservation
//   q_dst/q_is_cond : destination to test against all valid slots
//   conflict        : the landing cycle for rsv_lat is already taken
//   dst_match       : some valid slot targets q_dst/q_is_cond
//   head            : slot 1 contents
//   any_valid       : at least one slot is valid
module fpu_sched_rsv
   import fpu_sched_pkg::*;
#(
   parameter int MAX_LAT = 4,
   parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             rsv_en,
   input  logic [LAT_W-1:0] rsv_lat,
   input  slot_t            rsv_slot,
   input  logic [DST_W-1:0] q_dst,
   input  logic             q_is_cond,
   output logic             conflict,
   output logic             dst_match,
   output slot_t            head,
   output logic             any_valid
);

   slot_t tab [1:MAX_LAT];

   // The table shifts on the same edge that accepts the op, so a new op of
   // latency L goes into slot L after the shift and reaches slot 1 L cycles on.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int k = 1; k <= MAX_LAT; k++) tab[k] <= '0;
      end else begin
         for (int k = 1; k < MAX_LAT; k++) tab[k] <= tab[k+1];
         tab[MAX_LAT] <= '0;
         for (int k = 1; k <= MAX_LAT; k++) begin
            if (rsv_en && int'(rsv_lat) == k) tab[k] <= rsv_slot;
         end
      end
   end

   // Before the shift the landing slot of a latency-L op is slot L+1.
   always_comb begin
      conflict  = 1'b0;
      dst_match = 1'b0;
      any_valid = 1'b0;
      for (int k = 1; k <= MAX_LAT; k++) begin
         if (tab[k].valid) begin
            any_valid = 1'b1;
            if (tab[k].dst == q_dst && tab[k].is_cond == q_is_cond) dst_match = 1'b1;
            if (rsv_lat != '0 && k == int'(rsv_lat) + 1) conflict = 1'b1;
         end
      end
   end

   assign head = tab[1];

endmodule

// File: rtl/fpu_scheduler.sv
// FPU issue scheduler: accepts ops from the core, strobes the execution
// units, arbitrates the single write-back port with a reservation table and
// tracks the non-pipelined divider.
// Ports:
//   CLK, RST_N : clock, synchronous active-low reset
//   sif        : fpu_sched_if.slave (issue handshake + write-back port)
//   unit_go    : one-hot start strobe, bit index = op code (ADD..ITOF)
//   div_done   : divider result-valid pulse
//   busy       : any result in flight or pending
//   stat_issue, stat_stall : present only with FPU_SCHED_STATS_EN defined
//
// Divider state table:
//   state    | meaning
//   DIV_IDLE | divider free, no divide result owed
//   DIV_RUN  | divide issued, waiting for div_done
//   DIV_PEND | div_done seen while slot 1 was taken, result waits for a free slot
module fpu_scheduler
   import fpu_sched_pkg::*;
#(
   parameter int ADD_LAT  = 4,
   parameter int MUL_LAT  = 3,
   parameter int ITOF_LAT = 2
) (
   input  logic               CLK,
   input  logic               RST_N,
   fpu_sched_if.slave         sif,
   output logic [N_UNITS-1:0] unit_go,
   input  logic               div_done,
   output logic               busy
`ifdef FPU_SCHED_STATS_EN
   ,
   output logic [31:0]        stat_issue,
   output logic [31:0]        stat_stall
`endif
);

   localparam int MAX_LAT = max_of(max_of(max_of(ADD_LAT, MUL_LAT), max_of(ITOF_LAT, CMP_LAT)), MOV_LAT);
   localparam int LAT_W   = $clog2(MAX_LAT + 1);

   div_state_t       div_st;
   logic [DST_W-1:0] div_dst;
   logic             div_cond;

   logic [LAT_W-1:0] req_lat;
   logic             fixed_op;
   logic             op_legal;
   logic             conflict;
   logic             dst_match;
   logic             any_valid;
   slot_t            head;
   slot_t            head_v;
   slot_t            rsv_slot;
   logic             div_active;
   logic             div_waw;
   logic             div_wb;
   logic             accept;

   always_comb begin
      req_lat  = '0;
      fixed_op = 1'b1;
      op_legal = 1'b1;
      case (sif.req_op)
         ADD, SUB: req_lat = LAT_W'(ADD_LAT);
         MUL:      req_lat = LAT_W'(MUL_LAT);
         ITOF:     req_lat = LAT_W'(ITOF_LAT);
         CMP:      req_lat = LAT_W'(CMP_LAT);
         MOV:      req_lat = LAT_W'(MOV_LAT);
         DIV:      fixed_op = 1'b0;
         default: begin
            fixed_op = 1'b0;
            op_legal = 1'b0;
         end
      endcase
   end

   assign rsv_slot = '{valid: 1'b1, op: sif.req_op, dst: sif.req_dst, is_cond: sif.req_is_cond};

   fpu_sched_rsv #(
      .MAX_LAT (MAX_LAT),
      .LAT_W   (LAT_W)
   ) u_rsv (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .rsv_en    (accept && fixed_op),
      .rsv_lat   (req_lat),
      .rsv_slot  (rsv_slot),
      .q_dst     (sif.req_dst),
      .q_is_cond (sif.req_is_cond),
      .conflict  (conflict),
      .dst_match (dst_match),
      .head      (head),
      .any_valid (any_valid)
   );

   // While RST_N is low the registered state is about to be cleared, so every
   // output is computed as if it already were.
   assign head_v     = RST_N ? head : '0;
   assign div_active = RST_N && (div_st != DIV_IDLE);
   assign div_waw    = div_active && (div_dst == sif.req_dst) && (div_cond == sif.req_is_cond);

   assign sif.req_ready = op_legal
                          && !(RST_N && conflict)
                          && !(RST_N && dst_match)
                          && !div_waw
                          && !(div_active && sif.req_op == DIV)
                          && !(RST_N && div_st == DIV_PEND);

   assign accept  = RST_N && sif.req_valid && sif.req_ready;
   assign unit_go = (accept && sif.req_op != MOV) ? (N_UNITS'(1) << sif.req_op) : '0;

   // Fixed-latency results own slot 1; the divide result only takes an empty one.
   assign div_wb = RST_N && !head.valid
                   && ((div_st == DIV_RUN && div_done) || div_st == DIV_PEND);

   always_comb begin
      sif.wb_valid   = 1'b0;
      sif.wb_sel     = ADD;
      sif.wb_dst     = '0;
      sif.wb_is_cond = 1'b0;
      if (head_v.valid) begin
         sif.wb_valid   = 1'b1;
         sif.wb_sel     = head_v.op;
         sif.wb_dst     = head_v.dst;
         sif.wb_is_cond = head_v.is_cond;
      end else if (div_wb) begin
         sif.wb_valid   = 1'b1;
         sif.wb_sel     = DIV;
         sif.wb_dst     = div_dst;
         sif.wb_is_cond = div_cond;
      end
   end

   assign busy = (RST_N && any_valid) || div_active;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         div_st   <= DIV_IDLE;
         div_dst  <= '0;
         div_cond <= 1'b0;
      end else begin
         case (div_st)
            DIV_IDLE: begin
               if (accept && sif.req_op == DIV) begin
                  div_st   <= DIV_RUN;
                  div_dst  <= sif.req_dst;
                  div_cond <= sif.req_is_cond;
               end
            end
            DIV_RUN: begin
               if (div_done) div_st <= head.valid ? DIV_PEND : DIV_IDLE;
            end
            DIV_PEND: begin
               if (!head.valid) div_st <= DIV_IDLE;
            end
            default: div_st <= DIV_IDLE;
         endcase
      end
   end

`ifdef FPU_SCHED_STATS_EN
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         stat_issue <= '0;
         stat_stall <= '0;
      end else begin
         if (accept) stat_issue <= stat_issue + 32'd1;
         if (sif.req_valid && !sif.req_ready) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fpu_scheduler.sv
// Testbench for fpu_scheduler: directed scenarios followed by random traffic,
// all checked against an event-list model of write-back cycles.
module tb_fpu_scheduler;
   import fpu_sched_pkg::*;

   localparam int ADD_LAT  = 4;
   localparam int MUL_LAT  = 3;
   localparam int ITOF_LAT = 2;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       div_done = 1'b0;
   logic [5:0] unit_go;
   logic       busy;
`ifdef FPU_SCHED_STATS_EN
   logic [31:0] stat_issue;
   logic [31:0] stat_stall;
`endif

   fpu_sched_if sif ();

   fpu_scheduler #(
      .ADD_LAT  (ADD_LAT),
      .MUL_LAT  (MUL_LAT),
      .ITOF_LAT (ITOF_LAT)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .sif      (sif),
      .unit_go  (unit_go),
      .div_done (div_done),
      .busy     (busy)
`ifdef FPU_SCHED_STATS_EN
      ,
      .stat_issue (stat_issue),
      .stat_stall (stat_stall)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         land;
      op_t        op;
      logic [4:0] dst;
      logic       cond;
   } wb_ev_t;

   wb_ev_t     sched[$];
   int         cyc = 0;
   int         dstate = 0;   // 0 idle, 1 divide running, 2 divide result waiting
   logic [4:0] m_div_dst = '0;
   logic       m_div_cond = 1'b0;
   int         m_issue = 0;
   int         m_stall = 0;

   int         n_checks = 0;
   int         n_fail = 0;

   logic       obs_ready;
   logic [5:0] obs_go;
   logic [9:0] obs_wb;
   logic       obs_busy;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int lat_of(input op_t op);
      case (op)
         ADD, SUB: return ADD_LAT;
         MUL:      return MUL_LAT;
         ITOF:     return ITOF_LAT;
         CMP, MOV: return 1;
         default:  return 0;
      endcase
   endfunction

   // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
   task automatic step(input logic rst_n, input logic v, input op_t op,
                       input logic [4:0] dst, input logic cond, input logic done);
      bit         exp_rdy;
      bit         acc;
      bit         has_head;
      bit         exp_busy;
      wb_ev_t     h;
      logic [9:0] exp_wb;
      logic [5:0] exp_go;
      int         lat;

      RST_N           = rst_n;
      sif.req_valid   = v;
      sif.req_op      = op;
      sif.req_dst     = dst;
      sif.req_is_cond = cond;
      div_done        = done;
      @(negedge CLK);

      for (int i = sched.size() - 1; i >= 0; i--) begin
         if (sched[i].land < cyc) sched.delete(i);
      end

      lat      = lat_of(op);
      has_head = 1'b0;
      h        = '{0, ADD, 5'd0, 1'b0};
      foreach (sched[i]) begin
         if (sched[i].land == cyc) begin
            has_head = 1'b1;
            h        = sched[i];
         end
      end

      if (!rst_n) begin
         exp_rdy  = 1'b1;
         acc      = 1'b0;
         exp_go   = '0;
         exp_wb   = '0;
         exp_busy = 1'b0;
      end else begin
         exp_rdy = 1'b1;
         if (dstate == 2) exp_rdy = 1'b0;
         if (op == DIV && dstate != 0) exp_rdy = 1'b0;
         if (dstate != 0 && m_div_dst == dst && m_div_cond == cond) exp_rdy = 1'b0;
         foreach (sched[i]) begin
            if (sched[i].dst == dst && sched[i].cond == cond) exp_rdy = 1'b0;
            if (op != DIV && sched[i].land == cyc + lat) exp_rdy = 1'b0;
         end
         acc    = v && exp_rdy;
         exp_go = (acc && op != MOV) ? 6'(1 << int'(op)) : 6'd0;
         if (has_head)
            exp_wb = {1'b1, h.op, h.dst, h.cond};
         else if ((dstate == 1 && done) || dstate == 2)
            exp_wb = {1'b1, DIV, m_div_dst, m_div_cond};
         else
            exp_wb = '0;
         exp_busy = (sched.size() > 0) || (dstate != 0);
      end

      obs_ready = sif.req_ready;
      obs_go    = unit_go;
      obs_wb    = {sif.wb_valid, sif.wb_sel, sif.wb_dst, sif.wb_is_cond};
      obs_busy  = busy;
      check("ready", obs_ready, exp_rdy);
      check("unit_go", obs_go, exp_go);
      check("wb", obs_wb, exp_wb);
      check("busy", obs_busy, exp_busy);

      if (!rst_n) begin
         sched.delete();
         dstate  = 0;
         m_issue = 0;
         m_stall = 0;
      end else begin
         if (acc) m_issue++;
         if (v && !exp_rdy) m_stall++;
         if (acc && op != DIV) sched.push_back('{cyc + lat, op, dst, cond});
         case (dstate)
            0: if (acc && op == DIV) begin
                  dstate     = 1;
                  m_div_dst  = dst;
                  m_div_cond = cond;
               end
            1: if (done) dstate = has_head ? 2 : 0;
            2: if (!has_head) dstate = 0;
            default: dstate = 0;
         endcase
      end
      cyc++;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, ADD, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      sif.req_valid   = 1'b0;
      sif.req_op      = ADD;
      sif.req_dst     = '0;
      sif.req_is_cond = 1'b0;

      // reset with pending-looking stimulus
      step(1'b0, 1'b0, ADD, 5'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, MUL, 5'd3, 1'b0, 1'b1);
      check("rst_wb_valid", obs_wb[9], 1'b0);
      check("rst_busy", obs_busy, 1'b0);
      idle(2);

      // MUL dst 3: strobe now, write-back exactly 3 cycles later
      step(1'b1, 1'b1, MUL, 5'd3, 1'b0, 1'b0);
      check("mul_go", obs_go, 6'b000100);
      idle(2);
      check("mul_wb_early", obs_wb[9], 1'b0);
      idle(1);
      check("mul_wb", obs_wb, {1'b1, MUL, 5'd3, 1'b0});
      idle(1);
      check("mul_wb_late", obs_wb[9], 1'b0);
      idle(4);

      // ADD then MUL landing in the same cycle
      step(1'b1, 1'b1, ADD, 5'd1, 1'b0, 1'b0);
      step(1'b1, 1'b1, MUL, 5'd2, 1'b0, 1'b0);
      check("port_conflict", obs_ready, 1'b0);
      step(1'b1, 1'b1, MUL, 5'd2, 1'b0, 1'b0);
      check("mul_retry", obs_ready, 1'b1);
      idle(2);
      check("add_wb", obs_wb, {1'b1, ADD, 5'd1, 1'b0});
      idle(1);
      check("mul_wb2", obs_wb, {1'b1, MUL, 5'd2, 1'b0});
      idle(4);

      // WAW: same dst, cond flag distinguishes the register files
      step(1'b1, 1'b1, ADD, 5'd5, 1'b0, 1'b0);
      step(1'b1, 1'b1, CMP, 5'd5, 1'b1, 1'b0);
      check("waw_other_file", obs_ready, 1'b1);
      step(1'b1, 1'b1, CMP, 5'd5, 1'b0, 1'b0);
      check("waw_block_c2", obs_ready, 1'b0);
      step(1'b1, 1'b1, CMP, 5'd5, 1'b0, 1'b0);
      check("waw_block_c3", obs_ready, 1'b0);
      step(1'b1, 1'b1, CMP, 5'd5, 1'b0, 1'b0);
      step(1'b1, 1'b1, CMP, 5'd5, 1'b0, 1'b0);
      check("waw_release", obs_ready, 1'b1);
      idle(4);

      // div_done while idle is ignored
      step(1'b1, 1'b0, ADD, 5'd0, 1'b0, 1'b1);
      check("stray_done", obs_wb[9], 1'b0);

      // DIV pushed to PEND by an ADD landing on div_done
      step(1'b1, 1'b1, DIV, 5'd7, 1'b0, 1'b0);
      check("div_go", obs_go, 6'b001000);
      step(1'b1, 1'b1, ADD, 5'd9, 1'b0, 1'b0);
      idle(3);
      step(1'b1, 1'b0, ADD, 5'd0, 1'b0, 1'b1);
      check("add_beats_div", obs_wb, {1'b1, ADD, 5'd9, 1'b0});
      step(1'b1, 1'b1, CMP, 5'd12, 1'b0, 1'b0);
      check("pend_ready", obs_ready, 1'b0);
      check("div_wb", obs_wb, {1'b1, DIV, 5'd7, 1'b0});
      step(1'b1, 1'b1, CMP, 5'd12, 1'b0, 1'b0);
      check("post_pend_ready", obs_ready, 1'b1);
      idle(4);

      // reset with ADD and DIV in flight, then a late div_done
      step(1'b1, 1'b1, ADD, 5'd4, 1'b0, 1'b0);
      step(1'b1, 1'b1, DIV, 5'd6, 1'b0, 1'b0);
      step(1'b0, 1'b0, ADD, 5'd0, 1'b0, 1'b0);
      idle(1);
      check("post_rst_busy", obs_busy, 1'b0);
      step(1'b1, 1'b0, ADD, 5'd0, 1'b0, 1'b1);
      check("late_done", obs_wb[9], 1'b0);
      idle(4);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 299) != 0),
              ($urandom_range(0, 3) != 0),
              op_t'($urandom_range(0, 6)),
              5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0));
      end
      idle(8);

`ifdef FPU_SCHED_STATS_EN
      check("stat_issue_rand", stat_issue, 64'(m_issue));
      check("stat_stall_rand", stat_stall, 64'(m_stall));

      step(1'b0, 1'b0, ADD, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, CMP, 5'(i), 1'b0, 1'b0);
      step(1'b1, 1'b1, ADD, 5'd20, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, CMP, 5'd20, 1'b0, 1'b0);
      idle(3);
      check("stat_issue", stat_issue, 64'd10);
      check("stat_stall", stat_stall, 64'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_scheduler.md
FPU_SCHEDULER -- requirements
Module: fpu_scheduler

Interface
- REQ-001: The block SHALL have parameter ADD_LAT, default 4, giving the add/sub result latency in cycles.
- REQ-002: The block SHALL have parameter MUL_LAT, default 3, giving the multiply latency.
- REQ-003: The block SHALL have parameter ITOF_LAT, default 2, giving the int-to-float latency.
- REQ-004: The block SHALL have port CLK, input, 1 bit: the single clock.
- REQ-005: The block SHALL have port RST_N, input, 1 bit: synchronous, active-low reset.
- REQ-006: The block SHALL have ports req_valid (in, 1), req_ready (out, 1), req_op (in, 3, op_t), req_dst (in, 5) and req_is_cond (in, 1): the issue handshake from the core.
- REQ-007: The block SHALL have port unit_go, output, 6 bits: one-hot start strobe for ADD, SUB, MUL, DIV, CMP and ITOF.
- REQ-008: The block SHALL have port div_done, input, 1 bit: the divider result-valid pulse.
- REQ-009: The block SHALL have ports wb_valid (out, 1), wb_sel (out, 3, op_t), wb_dst (out, 5) and wb_is_cond (out, 1): the single shared write-back port.
- REQ-010: The block SHALL have port busy, output, 1 bit: high while any operation is in flight or pending.

Function
- REQ-011: Latencies SHALL be fixed: CMP = 1 and MOV = 1 (MOV produces no unit_go); ADD/SUB = ADD_LAT; MUL = MUL_LAT; ITOF = ITOF_LAT; DIV completes on div_done.
- REQ-012: An operation SHALL be accepted on a rising CLK edge where req_valid and req_ready are both 1, and unit_go SHALL pulse combinationally in that same cycle for exactly one cycle.
- REQ-013: A write-back reservation table of depth MAX_LAT (the maximum of the latencies) SHALL shift down by one slot per cycle; slot 1 drives wb_* in the current cycle.
- REQ-014: Accepting a fixed-latency op of latency L SHALL write slot L (the slot that reaches slot 1 in L cycles), so wb_valid is high exactly L cycles after acceptance.
- REQ-015: req_ready SHALL be 0 when slot L is already reserved (write-back port conflict).
- REQ-016: req_ready SHALL be 0 when req_dst with matching req_is_cond equals the destination of any valid slot, the in-flight DIV, or the pending DIV (WAW hazard).
- REQ-017: req_ready SHALL be 0 for DIV while the divider is busy or a DIV result is pending, because the divider is non-pipelined.
- REQ-018: DIV states SHALL be IDLE -> RUN on acceptance; RUN -> IDLE on div_done if slot 1 is empty in that cycle (write back immediately); otherwise RUN -> PEND.
- REQ-019: In PEND, the DIV result SHALL be written back in the first cycle slot 1 is empty, then return to IDLE; no new op SHALL be accepted while in PEND.
- REQ-020: div_done received in IDLE or PEND SHALL be ignored.
- REQ-021: When req_valid = 0, req_ready SHALL still reflect acceptability and the block SHALL hold no state for the request.
- REQ-022: busy SHALL equal (any slot valid) OR (DIV state != IDLE).

Reset
- REQ-023: While RST_N = 0 at a CLK edge, all slots SHALL be cleared, the DIV state SHALL be IDLE, and the statistics counters SHALL be zeroed.
- REQ-024: During and after reset, wb_valid = 0, unit_go = 0, busy = 0, wb_sel/wb_dst/wb_is_cond = 0, and req_ready SHALL follow the cleared state.
- REQ-025: Reset mid-operation SHALL discard in-flight results without any write-back; a late div_done after reset SHALL be ignored.

Configuration
- REQ-026: With FPU_SCHED_STATS_EN defined, the block SHALL add outputs stat_issue (32 bits; ops accepted) and stat_stall (32 bits; cycles with req_valid && !req_ready), both wrapping at 2^32.
- REQ-027: Without FPU_SCHED_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
- REQ-028: Package fpu_sched_pkg SHALL hold op_t (ADD, SUB, MUL, DIV, CMP, ITOF, MOV), the slot struct {valid, op, dst, is_cond}, CMP_LAT and MOV_LAT.
- REQ-029: The reservation table SHALL be sub-module fpu_sched_rsv (shift, reserve-at-L, conflict and destination-match query); the DIV FSM and handshake SHALL be in fpu_scheduler.

Verification
- REQ-030: MUL accepted to dst 3 at cycle 0 -> unit_go[MUL] = 1 in cycle 0; wb_valid = 1, wb_sel = MUL, wb_dst = 3 in cycle 3 only.
- REQ-031: ADD to dst 1 at cycle 0, then MUL to dst 2 requested at cycle 1 -> MUL rejected in cycle 1 (both land in cycle 4), accepted in cycle 2, write-back in cycle 5.
- REQ-032: ADD to dst 5 in flight, CMP with req_dst = 5 and req_is_cond = 1 -> accepted; CMP with req_dst = 5 and req_is_cond = 0 -> rejected until cycle 4.
- REQ-033: DIV to dst 7 in RUN, ADD accepted 4 cycles before div_done so slot 1 is busy on div_done -> DIV enters PEND, write-back next cycle with wb_sel = DIV, wb_dst = 7; req_ready = 0 during PEND.
- REQ-034: RST_N = 0 for one cycle with ADD and DIV in flight -> no wb_valid afterwards, busy = 0; a div_done 2 cycles later produces no write-back.
- REQ-035: With FPU_SCHED_STATS_EN defined, 10 accepts and 3 stall cycles -> stat_issue = 10 and stat_stall = 3.
